vga_sync_gen: RTL and testbench

//  Downstream consumer of contador_clk's pixel_rate enable. Runs horizontal
//  and vertical pixel counters, one step per pixel_rate pulse, and decodes

---
 rtl/vga_sync_gen.sv | 78 +++++++
 tb/tb_vga_sync_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-enabled VGA counters with registered sync/video/frame decode
module vga_sync_gen #(
  parameter int   H_DISP   = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_DISP   = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          CLK_NX,
  input  logic          reset,
  input  logic          pixel_rate,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          frame_tick
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_DISP);
  localparam logic [CW-1:0] V_VIS  = CW'(V_DISP);
  localparam logic [CW-1:0] HS_BEG = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_DISP + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_DISP + V_FP + V_SYNC);

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, vid_q, vid_d, ft_q, ft_d;
  logic          x_end, y_end;

  // next counter values, and sync/video decoded from them so outputs stay aligned with the counters
  always_comb begin
    x_end = x_q == H_MAX;
    y_end = y_q == V_MAX;
    x_d   = x_end ? '0 : x_q + CW'(1);
    y_d   = x_end ? (y_end ? '0 : y_q + CW'(1)) : y_q;
    hs_d  = (x_d >= HS_BEG && x_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (y_d >= VS_BEG && y_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    vid_d = x_d < H_VIS && y_d < V_VIS;
    ft_d  = pixel_rate && x_end && y_end;
  end

  // state advances only on pixel_rate; frame_tick is a one-cycle pulse
  always_ff @(posedge CLK_NX or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      vid_q <= 1'b0;
      ft_q  <= 1'b0;
    end else begin
      ft_q <= ft_d;
      if (pixel_rate) begin
        x_q   <= x_d;
        y_q   <= y_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        vid_q <= vid_d;
      end
    end
  end

  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign video_on   = vid_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks on a reduced-size frame plus default-timing hsync
module tb_vga_sync_gen;
  logic       clk = 1'b0, rst = 1'b1, pr = 1'b0;
  logic       hs, vs, vid, ft, d_hs, d_vs, d_vid, d_ft;
  logic [9:0] x, y, d_x, d_y;
  int total = 0, bad = 0;
  int ft_cnt = 0, vid_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  always #10 clk = ~clk;

  // reduced frame: H 8+2+3+2 = 15, V 4+1+2+1 = 8; hsync x in [10,13), vsync y in [5,7)
  vga_sync_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CW(10)
  ) u_s (
    .CLK_NX(clk), .reset(rst), .pixel_rate(pr),
    .hsync(hs), .vsync(vs), .video_on(vid),
    .pixel_x(x), .pixel_y(y), .frame_tick(ft)
  );

  // default 640x480 timing, one pixel per clock
  vga_sync_gen u_d (
    .CLK_NX(clk), .reset(rst), .pixel_rate(1'b1),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
    .pixel_x(d_x), .pixel_y(d_y), .frame_tick(d_ft)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    ft_cnt = 0; vid_cnt = 0; hs_cnt = 0; vs_cnt = 0;
  endtask

  // n pixels, 1-in-4 pulse; entered and left on a falling edge
  task automatic pix(input int n);
    for (int i = 0; i < n; i++) begin
      pr = 1'b1;
      @(negedge clk);
      pr = 1'b0;
      ft_cnt  += int'(ft);
      vid_cnt += int'(vid);
      hs_cnt  += int'(!hs);
      vs_cnt  += int'(!vs);
      repeat (3) begin
        @(negedge clk);
        ft_cnt += int'(ft);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    pix(5);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_vid", vid, 0);
    chk("rst_ft", ft_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first00_vid", vid, 0);
    pix(1);
    chk("first_x", x, 1);
    chk("first_vid", vid, 1);
    pix(8);
    chk("x9", x, 9);
    chk("x9_hs", hs, 1);
    chk("x9_vid", vid, 0);
    pix(1);
    chk("x10_hs", hs, 0);
    pix(2);
    chk("x12_hs", hs, 0);
    pix(1);
    chk("x13_hs", hs, 1);
    pix(2);
    chk("wrap_x", x, 0);
    chk("wrap_y", y, 1);
    chk("wrap_vid", vid, 1);
    clr();
    pix(15);
    chk("line_hs", hs_cnt, 3);
    chk("line_vid", vid_cnt, 8);
    clr();
    pix(90);
    chk("fwrap_x", x, 0);
    chk("fwrap_y", y, 0);
    chk("fwrap_vid", vid, 1);
    chk("fwrap_ft", ft_cnt, 1);
    clr();
    pix(120);
    chk("frame_vid", vid_cnt, 32);
    chk("frame_hs", hs_cnt, 24);
    chk("frame_vs", vs_cnt, 30);
    chk("frame_ft", ft_cnt, 1);
    pix(75);
    chk("y5_y", y, 5);
    chk("y5_vs", vs, 0);
    pix(29);
    chk("y6_vs", vs, 0);
    pix(1);
    chk("y7_vs", vs, 1);
    pix(15);
    chk("y0_vs", vs, 1);
    pix(9);
    repeat (37) @(negedge clk);
    chk("stall_x", x, 9);
    chk("stall_hs", hs, 1);
    chk("stall_y", y, 0);
    pix(1);
    chk("unstall_x", x, 10);
    chk("unstall_hs", hs, 0);
    pix(31);
    chk("mid_x", x, 11);
    chk("mid_y", y, 2);
    chk("mid_hs", hs, 0);
    #3 rst = 1'b1;
    #1;
    chk("async_x", x, 0);
    chk("async_y", y, 0);
    chk("async_hs", hs, 1);
    chk("async_vid", vid, 0);
    @(negedge clk);
    rst = 1'b0;
    pix(1);
    chk("restart_x", x, 1);
    chk("restart_vid", vid, 1);
    for (int i = 0; i < 2000 && d_x != 10'd655; i++) @(negedge clk);
    chk("d_x655", d_x, 655);
    chk("d_hs655", d_hs, 1);
    @(negedge clk);
    chk("d_hs656", d_hs, 0);
    repeat (95) @(negedge clk);
    chk("d_x751", d_x, 751);
    chk("d_hs751", d_hs, 0);
    @(negedge clk);
    chk("d_hs752", d_hs, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
